descrambler: RTL



---
 rtl/descrambler_pkg.sv | 18 +
 rtl/descrambler_if.sv | 27 ++
 rtl/scrambler_lfsr.sv | 36 +++
 rtl/descrambler.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/descrambler_pkg.sv
// Shared types and constants for the 802.11a receive descrambler and its LFSR core.
// Tap positions implement x^7 + x^4 + 1 on a left-shifting 7-bit state.
package descrambler_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEED = 2'd1,
      RUN  = 2'd2
   } state_e;

   localparam int SEED_BITS    = 7;
   localparam int SERVICE_BITS = 16;
   localparam int TAP_HI       = 6;
   localparam int TAP_LO       = 3;

   localparam logic [SEED_BITS-1:0] RESET_SEED = '0;

endpackage

// File: rtl/descrambler_if.sv
// Serial bit-stream bundle between the decoder path and the descrambler.
// master drives the scrambled stream, slave is the descrambler.
interface descrambler_if #(
   parameter int LEN_W = 12
) ();

   logic                                  start;
   logic                                  in_dat;
   logic                                  in_vld;
   logic [LEN_W-1:0]                      length;
   logic                                  out_dat;
   logic                                  out_vld;
   logic                                  done;
   logic [descrambler_pkg::SEED_BITS-1:0] seed_out;
   logic                                  service_err;

   modport master (
      output start, in_dat, in_vld, length,
      input  out_dat, out_vld, done, seed_out, service_err
   );

   modport slave (
      input  start, in_dat, in_vld, length,
      output out_dat, out_vld, done, seed_out, service_err
   );

endinterface

// File: rtl/scrambler_lfsr.sv
// 7-bit additive scrambler LFSR: when en, shifts in din (load) or its own feedback.
// fb is combinational from the current state; state_nxt previews the post-shift value.
module scrambler_lfsr
   import descrambler_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 load,
   input  logic                 din,
   output logic                 fb,
   output logic [SEED_BITS-1:0] state_nxt
);

   logic [SEED_BITS-1:0] state_q;
   logic [SEED_BITS-1:0] state_d;

   assign fb        = state_q[TAP_HI] ^ state_q[TAP_LO];
   assign state_nxt = state_d;

   always_comb begin
      state_d = state_q;
      if (en) begin
         state_d = {state_q[SEED_BITS-2:0], (load ? din : fb)};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RESET_SEED;
      end else begin
         state_q <= state_d;
      end
   end

endmodule

// File: rtl/descrambler.sv
// 802.11a serial descrambler: seeds from SERVICE bits 0..6, then strips x^7+x^4+1; 1-cycle latency.
// No backpressure: in_vld low stalls all state. DESCRAMBLER_SERVICE_CHECK_EN builds the SERVICE error flag.
module descrambler
   import descrambler_pkg::*;
#(
   parameter int LEN_W = 12,
   parameter int CNT_W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   descrambler_if.slave bus
);

   localparam logic [CNT_W-1:0] SEED_LAST = CNT_W'(SEED_BITS - 1);
   localparam logic [CNT_W-1:0] SVC_END   = CNT_W'(SERVICE_BITS);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0]     total_q, total_d;
   logic [SEED_BITS-1:0] seed_q, seed_d;
   logic                 out_q, out_d;
   logic                 out_vld_q, out_vld_d;
   logic                 done_q, done_d;

   logic [LEN_W-1:0]     len_w;
   logic [CNT_W-1:0]     idx;
   logic                 lfsr_en;
   logic                 lfsr_load;
   logic                 lfsr_fb;
   logic [SEED_BITS-1:0] lfsr_nxt;
   logic                 descr;

   assign len_w = bus.length;
   assign idx   = cnt_q + CNT_W'(1);
   assign descr = bus.in_dat ^ lfsr_fb;

   scrambler_lfsr u_lfsr (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (lfsr_en),
      .load      (lfsr_load),
      .din       (bus.in_dat),
      .fb        (lfsr_fb),
      .state_nxt (lfsr_nxt)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      total_d   = total_q;
      seed_d    = seed_q;
      out_d     = 1'b0;
      out_vld_d = 1'b0;
      done_d    = 1'b0;
      lfsr_en   = 1'b0;
      lfsr_load = 1'b0;
      if (bus.in_vld) begin
         // A valid Start always wins, so a mid-frame Start restarts cleanly.
         if (bus.start) begin
            state_d   = SEED;
            cnt_d     = '0;
            total_d   = SVC_END + (CNT_W'(len_w) << 3);
            out_vld_d = 1'b1;
            lfsr_en   = 1'b1;
            lfsr_load = 1'b1;
         end else begin
            case (state_q)
               SEED: begin
                  out_vld_d = 1'b1;
                  lfsr_en   = 1'b1;
                  lfsr_load = 1'b1;
                  cnt_d     = idx;
                  if (idx == SEED_LAST) begin
                     seed_d  = lfsr_nxt;
                     state_d = RUN;
                  end
               end
               RUN: begin
                  out_vld_d = 1'b1;
                  out_d     = descr;
                  lfsr_en   = 1'b1;
                  cnt_d     = idx;
                  if (idx == total_q - CNT_W'(1)) begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         total_q   <= '0;
         seed_q    <= RESET_SEED;
         out_q     <= 1'b0;
         out_vld_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         total_q   <= total_d;
         seed_q    <= seed_d;
         out_q     <= out_d;
         out_vld_q <= out_vld_d;
         done_q    <= done_d;
      end
   end

   assign bus.out_dat  = out_q;
   assign bus.out_vld  = out_vld_q;
   assign bus.done     = done_q;
   assign bus.seed_out = seed_q;

`ifdef DESCRAMBLER_SERVICE_CHECK_EN
   logic err_q, err_d;

   // Sticky within a frame; only a valid Start clears it.
   always_comb begin
      err_d = err_q;
      if (bus.in_vld) begin
         if (bus.start) begin
            err_d = 1'b0;
         end else if (state_q == SEED && idx == SEED_LAST && lfsr_nxt == '0) begin
            err_d = 1'b1;
         end else if (state_q == RUN && idx < SVC_END && descr) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign bus.service_err = err_q;
`else
   assign bus.service_err = 1'b0;
`endif

endmodule
